// File: rtl/interval_countdown_timer_if.sv
// Bundles the start request, the countdown value and the timer status outputs
// between the parameter selector, the timer and the anti-theft FSM.
interface interval_countdown_timer_if #(
    parameter int CNT_W = 4
);
    logic [CNT_W-1:0] value;
    logic             start_timer;
    logic             one_hz_enable;
    logic             two_hz_enable;
    logic             expired;
    logic             busy;
    logic [CNT_W-1:0] remaining;

    modport master (
        output value,
        output start_timer,
        input  one_hz_enable,
        input  two_hz_enable,
        input  expired,
        input  busy,
        input  remaining
    );

    modport slave (
        input  value,
        input  start_timer,
        output one_hz_enable,
        output two_hz_enable,
        output expired,
        output busy,
        output remaining
    );
endinterface

// File: rtl/interval_countdown_timer.sv
// Seconds countdown timer with free-running 1 Hz / 2 Hz enables; a start
// request resyncs the prescaler so the first second is always a full one.
//
//  state  | meaning
//  S_IDLE | after reset, nothing counting
//  S_RUN  | counting down, remaining holds seconds left
//  S_DONE | countdown finished, expired held until next start or reset
module interval_countdown_timer #(
    parameter int CLK_HZ = 100_000_000,
    parameter int CNT_W  = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    interval_countdown_timer_if.slave   bus
);
    localparam int HALF = CLK_HZ / 2;
    localparam int PW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] LAST = PW'(HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [PW-1:0]    r_prescaler;
    logic             r_phase;
    logic [CNT_W-1:0] r_remaining;
    logic             r_busy;
    logic             r_expired;

    logic w_two_hz;
    logic w_one_hz;

    assign w_two_hz = (r_prescaler == LAST);
    assign w_one_hz = w_two_hz & r_phase;

    always_ff @(posedge clock) begin
        if (reset || bus.start_timer) begin
            r_prescaler <= '0;
            r_phase     <= 1'b0;
        end else if (w_two_hz) begin
            r_prescaler <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_prescaler <= r_prescaler + PW'(1);
        end
    end

    // A start always wins over a coincident 1 Hz tick: reload, no decrement.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_expired   <= 1'b0;
        end else if (bus.start_timer) begin
            if (bus.value == '0) begin
                r_state     <= S_DONE;
                r_remaining <= '0;
                r_busy      <= 1'b0;
                r_expired   <= 1'b1;
            end else begin
                r_state     <= S_RUN;
                r_remaining <= bus.value;
                r_busy      <= 1'b1;
                r_expired   <= 1'b0;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_one_hz) begin
                        if (r_remaining > CNT_W'(1)) begin
                            r_remaining <= r_remaining - CNT_W'(1);
                        end else begin
                            r_state     <= S_DONE;
                            r_remaining <= '0;
                            r_busy      <= 1'b0;
                            r_expired   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign bus.two_hz_enable = w_two_hz;
    assign bus.one_hz_enable = w_one_hz;
    assign bus.busy          = r_busy;
    assign bus.expired       = r_expired;
    assign bus.remaining     = r_remaining;
endmodule

// File: doc/interval_countdown_timer.md
Name: interval_countdown_timer

Overview:
Timing stage between the time-parameter selector and the anti-theft control FSM. It derives free-running 1 Hz and 2 Hz single-cycle enables from the system clock. On a start request it counts down a 4-bit seconds value and flags expiry to the FSM. The 2 Hz enable also drives the siren generator, and the 1 Hz enable drives the FSM status blink.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz; must be even and >= 4 (benches use 8).
CNT_W, 4, width of the seconds value and countdown register.

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
value  input  CNT_W  countdown length in seconds; sampled only on start_timer.
start_timer  input  1  start/restart request; sampled on every rising edge.
one_hz_enable  output  1  single-cycle pulse, once per CLK_HZ cycles.
two_hz_enable  output  1  single-cycle pulse, once per CLK_HZ/2 cycles.
expired  output  1  level; high while the timer is in DONE.
busy  output  1  level; high while the timer is in RUN.
remaining  output  CNT_W  seconds left; 0 when IDLE or DONE.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: prescaler=0, phase=0, state=IDLE, remaining=0. All outputs are 0 on the cycle after the reset edge.
- Prescaler:
  - Counts 0..CLK_HZ/2-1 and wraps.
  - two_hz_enable is combinationally high while prescaler==CLK_HZ/2-1.
  - The phase bit toggles at each wrap.
  - one_hz_enable = two_hz_enable AND phase==1.
  - The prescaler free-runs in all states.
- Start resync: when start_timer is sampled high, prescaler and phase clear to 0. The first one_hz_enable after a start is therefore exactly CLK_HZ cycles after the start edge.
- FSM states:
  - IDLE: after reset. Outputs expired=0, busy=0.
  - RUN: busy=1. remaining holds the current count.
  - DONE: expired=1, busy=0, remaining=0. Holds until the next start_timer or reset.
- Transitions (evaluated at each rising edge, reset highest priority):
  - Any state, start_timer=1, value>0: remaining<=value, go to RUN.
  - Any state, start_timer=1, value==0: go to DONE; expired is high the next cycle (1-cycle latency).
  - RUN, one_hz_enable=1, remaining>1: remaining<=remaining-1.
  - RUN, one_hz_enable=1, remaining==1: remaining<=0, go to DONE.
- Latency: a start with value N>=1 at edge E0 makes expired rise at edge E0 + N*CLK_HZ.
- Simultaneous events:
  - start_timer with one_hz_enable in RUN: the start wins. Reload, no decrement.
  - start_timer in RUN restarts the count from the new value; this is not an error.
  - start_timer held high for several cycles reloads every cycle. No countdown progresses until it is released.
- value changes are ignored except on a start edge.
- Reset mid-run returns to IDLE immediately. No stale expired.
- Arithmetic is unsigned CNT_W bits. remaining never wraps below 0; the decrement only occurs when remaining>=2.
- The prescaler width is clog2(CLK_HZ/2). No other counters.

Test Plan:
1. Reset held for 3 cycles, CLK_HZ=8 -> all outputs 0. After release, two_hz_enable pulses every 4 cycles and one_hz_enable every 8 cycles, each exactly 1 cycle wide.
2. start_timer 1-cycle pulse, value=3 -> busy=1, remaining=3. remaining steps 3->2->1->0 at 8-cycle intervals. expired rises 24 cycles after the start edge and stays high for 100+ cycles.
3. start_timer with value=0 -> expired=1 on the next cycle, busy never asserts.
4. value=5 start, then a second start with value=2 after 12 cycles -> prescaler resyncs, remaining=2. expired rises 16 cycles after the second start.
5. start_timer asserted on the same edge as one_hz_enable in RUN with remaining=1 -> reload to the new value, no transition to DONE.
6. Reset asserted mid-RUN (remaining=4) -> next cycle: IDLE, remaining=0, busy=0, expired=0, prescaler=0.
